ble_packet_framer: RTL

BLE_PACKET_FRAMER -- requirements
Module: ble_packet_framer

---
 rtl/ble_rx_pkg.sv | 30 +++
 rtl/ble_aa_correlator.sv | 38 +++
 rtl/ble_packet_framer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive path: framer states, field sizes,
// popcount for the access-address correlator and the dewhitening LFSR step.
package ble_rx_pkg;

  localparam int   AA_WIDTH      = 32;
  localparam int   POP_W         = $clog2(AA_WIDTH + 1);
  localparam int   HDR_BYTES     = 2;
  localparam int   CRC_BYTES     = 3;
  localparam logic LFSR_INIT_MSB = 1'b1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } state_e;

  function automatic logic [POP_W-1:0] popcount_aa(input logic [AA_WIDTH-1:0] v);
    popcount_aa = '0;
    for (int i = 0; i < AA_WIDTH; i++) begin
      popcount_aa = popcount_aa + POP_W'(v[i]);
    end
  endfunction

  // x^7 + x^4 + 1: rotate left, feedback also folded into bit 4.
  function automatic logic [6:0] lfsr_next(input logic [6:0] l);
    lfsr_next    = {l[5:0], l[6]};
    lfsr_next[4] = l[3] ^ l[6];
  endfunction

endpackage

// File: rtl/ble_aa_correlator.sv
// Access-address correlator: LSB-first shift register and a Hamming-distance
// threshold compare evaluated on the register's next value.
module ble_aa_correlator
  import ble_rx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  input  logic                clear,
  input  logic                bit_in,
  input  logic [AA_WIDTH-1:0] access_address,
  input  logic [2:0]          err_max,
  output logic                hit
);

  logic [AA_WIDTH-1:0] aa_sr_q, aa_sr_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    aa_sr_d = clear ? '0 : aa_sr_q;
    if (shift_en) begin
      aa_sr_d = {bit_in, aa_sr_d[AA_WIDTH-1:1]};
    end
  end

  assign hit = shift_en &&
               (popcount_aa(aa_sr_d ^ access_address) <= {{(POP_W-3){1'b0}}, err_max});

  // NOTE: state updates use <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aa_sr_q <= '0;
    end else begin
      aa_sr_q <= aa_sr_d;
    end
  end

endmodule

// File: rtl/ble_packet_framer.sv
// BLE packet framer: AA search, LSB-first byte assembly, length-driven framing.
// Define BLE_DEWHITEN_EN to dewhiten post-AA bits with the channel-seeded LFSR.
module ble_packet_framer
  import ble_rx_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                bit_in,
  input  logic                bit_valid,
  input  logic [AA_WIDTH-1:0] access_address,
  input  logic [2:0]          aa_err_max,
  input  logic [5:0]          chan_idx,
  output logic                aa_match,
  output logic [7:0]          byte_data,
  output logic                byte_valid,
  output logic                byte_last,
  output logic                pkt_busy
);

  localparam logic [8:0] LAST_OFFSET = 9'(HDR_BYTES + CRC_BYTES - 1);

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [8:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] len_q, len_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] byte_data_q, byte_data_d;
  logic       aa_match_q, aa_match_d;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_last_q, byte_last_d;
  logic       data_bit, aa_shift, aa_clear, aa_hit;

  // The correlator only runs in SEARCH, so a mid-packet AA pattern cannot re-sync.
  assign aa_shift = en && bit_valid && (state_q == SEARCH);

  ble_aa_correlator u_corr (
    .clk            (clk),
    .rst            (rst),
    .shift_en       (aa_shift),
    .clear          (aa_clear),
    .bit_in         (bit_in),
    .access_address (access_address),
    .err_max        (aa_err_max),
    .hit            (aa_hit)
  );

`ifdef BLE_DEWHITEN_EN
  logic [6:0] lfsr_q, lfsr_d;

  assign data_bit = bit_in ^ lfsr_q[6];

  always_comb begin
    lfsr_d = lfsr_q;
    if (aa_hit) begin
      lfsr_d = {LFSR_INIT_MSB, chan_idx};
    end else if (en && bit_valid && (state_q != SEARCH)) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic chan_idx_unused;
  assign chan_idx_unused = ^chan_idx;
  assign data_bit        = bit_in;
`endif

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    aa_match_d   = 1'b0;
    byte_valid_d = 1'b0;
    byte_last_d  = 1'b0;
    aa_clear     = 1'b0;

    if (!en) begin
      state_d    = SEARCH;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      len_d      = '0;
      shift_d    = '0;
      aa_clear   = 1'b1;
    end else if (state_q == SEARCH) begin
      if (aa_hit) begin
        aa_match_d = 1'b1;
        state_d    = HEADER;
        bit_cnt_d  = '0;
        byte_cnt_d = '0;
        shift_d    = '0;
      end
    end else if (bit_valid) begin
      shift_d   = {data_bit, shift_q[7:1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_data_d  = shift_d;
        byte_cnt_d   = byte_cnt_q + 9'd1;
        if (state_q == HEADER) begin
          if (byte_cnt_q == 9'(HDR_BYTES - 1)) begin
            len_d   = shift_d;
            state_d = BODY;
          end
        end else if (byte_cnt_q == {1'b0, len_q} + LAST_OFFSET) begin
          // Final CRC byte: drop back to SEARCH with a clean correlator.
          byte_last_d = 1'b1;
          state_d     = SEARCH;
          byte_cnt_d  = '0;
          len_d       = '0;
          aa_clear    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= SEARCH;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      aa_match_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      len_q        <= len_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      aa_match_q   <= aa_match_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
    end
  end

  assign aa_match   = aa_match_q;
  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign pkt_busy   = (state_q == HEADER) || (state_q == BODY);

endmodule
